// File: rtl/bcd_seq_ctrl_if.sv
// Handshake and result bundle between the binary source and the BCD converter.
// Optional seven-segment output is present when SEG_DECODE_EN is defined.
interface bcd_seq_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
`ifdef SEG_DECODE_EN
  logic [7*DIGITS-1:0]   hex;

  modport master (output start, bin, input busy, done, bcd, hex);
  modport slave  (input start, bin, output busy, done, bcd, hex);
`else
  modport master (output start, bin, input busy, done, bcd);
  modport slave  (input start, bin, output busy, done, bcd);
`endif
endinterface

// File: rtl/bcd_seq_ctrl.sv
// Sequential double-dabble binary-to-BCD converter with start/busy/done handshake.
// Define SEG_DECODE_EN to add the active-low seven-segment hex output.
//
// state | meaning
// IDLE  | waiting for start; bcd holds the last result
// CONV  | one adjust-and-shift iteration per clock, WIDTH iterations
// DONE  | one-cycle done pulse after bcd update
module bcd_seq_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic         Clock,
  input  logic         Resetn,
  bcd_seq_ctrl_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam longint unsigned DEC_RANGE = longint'(10) ** DIGITS;
  localparam longint unsigned BIN_MAX   = (longint'(1) << WIDTH) - 1;

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("bcd_seq_ctrl: WIDTH must be at least 2");
    end
    if (DEC_RANGE <= BIN_MAX) begin : g_bad_digits
      $error("bcd_seq_ctrl: DIGITS too small to represent 2**WIDTH-1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t           state;
  logic [BW-1:0]    scratch;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    scratch_n;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_n;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bcd_q;
  logic             busy_q;
  logic             done_q;

  // One shared adjust stage: every nibble >= 5 gets +3, then the pair shifts left.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
    {scratch_n, shreg_n} = {adj, shreg} << 1;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= IDLE;
      scratch <= '0;
      shreg   <= '0;
      cnt     <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (bus.start) begin
            shreg   <= bus.bin;
            scratch <= '0;
            cnt     <= CW'(WIDTH);
            busy_q  <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          scratch <= scratch_n;
          shreg   <= shreg_n;
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd_q  <= scratch_n;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;

`ifdef SEG_DECODE_EN
  // Bit 0 is segment a, bit 6 is segment g; a 0 lights the segment.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
      assign bus.hex[7*g +: 7] = seg7(bcd_q[4*g +: 4]);
    end
  endgenerate
`endif

endmodule
